// File: rtl/counter_step_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : counter_step_ctrl
//  Purpose  : Command sequencer for the 8-bit LED counter. Turns debounced
//             inc/dec/clear button levels into one-cycle step/clear pulses,
//             with hold-to-repeat, inc/dec conflict lockout and optional
//             saturation at 8'h00 / 8'hFF.
//  Revision : 1.0 - initial release
// ============================================================================
module counter_step_ctrl #(
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter bit SATURATE      = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       inc_lvl,
    input  logic       dec_lvl,
    input  logic       clr_lvl,
    input  logic [7:0] count,
    output logic       inc_pulse,
    output logic       dec_pulse,
    output logic       clr_pulse,
    output logic       repeat_active
);

    localparam int c_MAX_CYCLES = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int c_TIMER_W    = (c_MAX_CYCLES > 1) ? $clog2(c_MAX_CYCLES) : 1;
    localparam logic [c_TIMER_W-1:0] c_HOLD_LAST   = c_TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [c_TIMER_W-1:0] c_REPEAT_LAST = c_TIMER_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HOLD    = 2'd1,
        S_REPEAT  = 2'd2,
        S_LOCKOUT = 2'd3
    } state_t;

    state_t                 r_state;
    logic [c_TIMER_W-1:0]   r_timer;
    logic                   r_dir_up;
    logic                   r_inc_prev;
    logic                   r_dec_prev;
    logic                   r_clr_prev;

    state_t                 w_state_nxt;
    logic [c_TIMER_W-1:0]   w_timer_nxt;
    logic                   w_dir_up_nxt;
    logic                   w_step;
    logic                   w_clr_cmd;
    logic                   w_inc_rise;
    logic                   w_dec_rise;
    logic                   w_clr_rise;
    logic                   w_active;
    logic                   w_opposite;
    logic [c_TIMER_W-1:0]   w_last;
    logic                   w_up_ok;
    logic                   w_dn_ok;

    assign w_inc_rise = inc_lvl & ~r_inc_prev;
    assign w_dec_rise = dec_lvl & ~r_dec_prev;
    assign w_clr_rise = clr_lvl & ~r_clr_prev;
    assign w_active   = r_dir_up ? inc_lvl : dec_lvl;
    assign w_opposite = r_dir_up ? dec_lvl : inc_lvl;
    assign w_last     = (r_state == S_HOLD) ? c_HOLD_LAST : c_REPEAT_LAST;
    // Saturation only masks the pulse; the FSM and timer behave as if it fired.
    assign w_up_ok    = !(SATURATE && (count == 8'hFF));
    assign w_dn_ok    = !(SATURATE && (count == 8'h00));

    // Next-state, timer and step decision; clear has absolute priority.
    always_comb begin
        w_state_nxt  = r_state;
        w_timer_nxt  = r_timer;
        w_dir_up_nxt = r_dir_up;
        w_step       = 1'b0;
        w_clr_cmd    = 1'b0;
        if (w_clr_rise) begin
            w_clr_cmd   = 1'b1;
            w_state_nxt = S_IDLE;
            w_timer_nxt = '0;
        end else if (clr_lvl) begin
            w_state_nxt = S_IDLE;
            w_timer_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_inc_rise && !dec_lvl) begin
                        w_step       = 1'b1;
                        w_dir_up_nxt = 1'b1;
                        w_timer_nxt  = '0;
                        w_state_nxt  = S_HOLD;
                    end else if (w_dec_rise && !inc_lvl) begin
                        w_step       = 1'b1;
                        w_dir_up_nxt = 1'b0;
                        w_timer_nxt  = '0;
                        w_state_nxt  = S_HOLD;
                    end else if (w_inc_rise || w_dec_rise) begin
                        w_state_nxt  = S_LOCKOUT;
                    end
                end
                S_HOLD, S_REPEAT: begin
                    if (!w_active) begin
                        w_state_nxt = S_IDLE;
                        w_timer_nxt = '0;
                    end else if (w_opposite) begin
                        w_state_nxt = S_LOCKOUT;
                    end else if (r_timer == w_last) begin
                        w_step      = 1'b1;
                        w_timer_nxt = '0;
                        w_state_nxt = S_REPEAT;
                    end else begin
                        w_timer_nxt = r_timer + 1'b1;
                    end
                end
                S_LOCKOUT: begin
                    if (!inc_lvl && !dec_lvl) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_timer_nxt = '0;
                end
            endcase
        end
    end

    // State, edge-history and registered command outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_timer       <= '0;
            r_dir_up      <= 1'b1;
            // Edge history tracks the buttons even in reset, so a button held
            // through reset is not seen as a fresh press on release.
            r_inc_prev    <= inc_lvl;
            r_dec_prev    <= dec_lvl;
            r_clr_prev    <= clr_lvl;
            inc_pulse     <= 1'b0;
            dec_pulse     <= 1'b0;
            clr_pulse     <= 1'b0;
            repeat_active <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_timer       <= w_timer_nxt;
            r_dir_up      <= w_dir_up_nxt;
            r_inc_prev    <= inc_lvl;
            r_dec_prev    <= dec_lvl;
            r_clr_prev    <= clr_lvl;
            inc_pulse     <= w_step &  w_dir_up_nxt & w_up_ok;
            dec_pulse     <= w_step & ~w_dir_up_nxt & w_dn_ok;
            clr_pulse     <= w_clr_cmd;
            repeat_active <= (w_state_nxt == S_REPEAT);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_counter_step_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_counter_step_ctrl
//  Purpose  : Directed self-checking bench for counter_step_ctrl; a wrapping
//             (SATURATE=0) and a saturating (SATURATE=1) instance share stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_counter_step_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       inc_lvl;
    logic       dec_lvl;
    logic       clr_lvl;
    logic [7:0] count;
    logic       inc_pulse_w, dec_pulse_w, clr_pulse_w, repeat_active_w;
    logic       inc_pulse_s, dec_pulse_s, clr_pulse_s, repeat_active_s;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    counter_step_ctrl #(.HOLD_CYCLES(8), .REPEAT_CYCLES(3), .SATURATE(1'b0)) u_dut_wrap (
        .clk(clk), .reset_n(reset_n), .inc_lvl(inc_lvl), .dec_lvl(dec_lvl),
        .clr_lvl(clr_lvl), .count(count), .inc_pulse(inc_pulse_w),
        .dec_pulse(dec_pulse_w), .clr_pulse(clr_pulse_w), .repeat_active(repeat_active_w)
    );

    counter_step_ctrl #(.HOLD_CYCLES(8), .REPEAT_CYCLES(3), .SATURATE(1'b1)) u_dut_sat (
        .clk(clk), .reset_n(reset_n), .inc_lvl(inc_lvl), .dec_lvl(dec_lvl),
        .clr_lvl(clr_lvl), .count(count), .inc_pulse(inc_pulse_s),
        .dec_pulse(dec_pulse_s), .clr_pulse(clr_pulse_s), .repeat_active(repeat_active_s)
    );

    task automatic check_val(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got {inc,dec,clr,rep}=%b expected %b", tag, obs, exp);
        end
    endtask

    // Advance one clock and check both instances; vector = {inc,dec,clr,rep}.
    task automatic cyc2(input string tag, input logic [3:0] exp_w, input logic [3:0] exp_s);
        @(posedge clk);
        #1;
        check_val({tag, "/wrap"}, {inc_pulse_w, dec_pulse_w, clr_pulse_w, repeat_active_w}, exp_w);
        check_val({tag, "/sat"},  {inc_pulse_s, dec_pulse_s, clr_pulse_s, repeat_active_s}, exp_s);
    endtask

    task automatic cyc(input string tag, input logic [3:0] exp);
        cyc2(tag, exp, exp);
    endtask

    initial begin
        reset_n = 1'b0;
        inc_lvl = 1'b1;
        dec_lvl = 1'b0;
        clr_lvl = 1'b0;
        count   = 8'h80;

        // Reset with inc held: outputs low, held level does not fire on release.
        cyc("reset0", 4'b0000);
        cyc("reset1", 4'b0000);
        reset_n = 1'b1;
        cyc("post_reset_held0", 4'b0000);
        cyc("post_reset_held1", 4'b0000);
        inc_lvl = 1'b0;
        cyc("post_reset_rel", 4'b0000);

        // Short tap: one pulse right after the rising edge.
        inc_lvl = 1'b1;
        cyc("tap_edge", 4'b1000);
        for (int k = 1; k < 4; k++) cyc("tap_hold", 4'b0000);
        inc_lvl = 1'b0;
        cyc("tap_rel", 4'b0000);

        // Long hold: pulses at N, N+8, N+11, N+14, N+17; repeat from N+8.
        inc_lvl = 1'b1;
        for (int k = 0; k < 20; k++) begin
            logic p;
            logic r;
            p = (k == 0) || (k == 8) || (k == 11) || (k == 14) || (k == 17);
            r = (k >= 8);
            cyc("long_hold", {p, 1'b0, 1'b0, r});
        end
        inc_lvl = 1'b0;
        cyc("long_rel", 4'b0000);

        // Conflict: dec in REPEAT, then inc rises -> lockout until both released.
        dec_lvl = 1'b1;
        for (int k = 0; k < 9; k++) begin
            logic p;
            p = (k == 0) || (k == 8);
            cyc("dec_hold", {1'b0, p, 1'b0, (k >= 8)});
        end
        inc_lvl = 1'b1;
        cyc("conflict_enter", 4'b0000);
        for (int k = 0; k < 5; k++) cyc("conflict_lock", 4'b0000);
        dec_lvl = 1'b0;
        cyc("conflict_inc_only", 4'b0000);
        inc_lvl = 1'b0;
        cyc("conflict_both_rel", 4'b0000);
        dec_lvl = 1'b1;
        cyc("conflict_dec_again", 4'b0100);
        dec_lvl = 1'b0;
        cyc("conflict_dec_rel", 4'b0000);

        // Simultaneous rise of both buttons: no step.
        inc_lvl = 1'b1;
        dec_lvl = 1'b1;
        cyc("both_rise", 4'b0000);
        cyc("both_held", 4'b0000);
        inc_lvl = 1'b0;
        dec_lvl = 1'b0;
        cyc("both_rel", 4'b0000);

        // Saturation at 8'hFF (up) and 8'h00 (down); FSM timing unchanged.
        count   = 8'hFF;
        inc_lvl = 1'b1;
        cyc2("sat_inc_ff", 4'b1000, 4'b0000);
        inc_lvl = 1'b0;
        cyc("sat_inc_rel", 4'b0000);
        count   = 8'h00;
        dec_lvl = 1'b1;
        for (int k = 0; k < 12; k++) begin
            logic p;
            logic r;
            p = (k == 0) || (k == 8) || (k == 11);
            r = (k >= 8);
            cyc2("sat_dec_00", {1'b0, p, 1'b0, r}, {1'b0, 1'b0, 1'b0, r});
        end
        dec_lvl = 1'b0;
        cyc("sat_dec_rel", 4'b0000);
        count   = 8'h80;

        // Clear during inc REPEAT.
        inc_lvl = 1'b1;
        for (int k = 0; k < 9; k++) begin
            logic p;
            p = (k == 0) || (k == 8);
            cyc("clr_pre", {p, 1'b0, 1'b0, (k >= 8)});
        end
        clr_lvl = 1'b1;
        cyc("clr_edge", 4'b0010);
        for (int k = 0; k < 4; k++) cyc("clr_held", 4'b0000);
        clr_lvl = 1'b0;
        for (int k = 0; k < 5; k++) cyc("clr_inc_still_held", 4'b0000);
        inc_lvl = 1'b0;
        cyc("clr_inc_rel", 4'b0000);
        inc_lvl = 1'b1;
        cyc("clr_repress", 4'b1000);
        inc_lvl = 1'b0;
        cyc("clr_repress_rel", 4'b0000);

        // Reset in REPEAT aborts with no further pulses.
        inc_lvl = 1'b1;
        for (int k = 0; k < 9; k++) begin
            logic p;
            p = (k == 0) || (k == 8);
            cyc("rst_pre", {p, 1'b0, 1'b0, (k >= 8)});
        end
        reset_n = 1'b0;
        cyc("rst_mid", 4'b0000);
        reset_n = 1'b1;
        for (int k = 0; k < 12; k++) cyc("rst_after", 4'b0000);
        inc_lvl = 1'b0;
        cyc("rst_rel", 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
